uart_tx_arbiter: RTL

Round-robin arbiter and sequencer that shares the single UART_Tx transmitter between up to NREQ byte sources, e.g. Message_Reg guess traffic and game-status/score senders. It sits between the requesters and UART_Tx and owns the tx_ctrl/tx_byte handshake. It supports per-requester message locking so multi-byte messages are never interleaved. It also detects a transmitter that never starts.

---
 rtl/hangman_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared types for the UART transmit arbiter: sequencer states and byte/index widths.
package hangman_pkg;

  localparam int BYTE_W = 8;
  localparam int ID_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_ACCEPT,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART_Tx-side signals of the transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  import hangman_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [BYTE_W*NREQ-1:0] req_byte;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        req_ack;
  logic                   tx_ctrl;
  logic [BYTE_W-1:0]      tx_byte;
  logic                   transmit_ready;
  logic [ID_W-1:0]        grant_id;
  logic                   busy;
  logic                   timeout_err;
  logic                   err_clr;

  modport slave (
    input  req_valid, req_byte, req_lock, transmit_ready, err_clr,
    output req_ack, tx_ctrl, tx_byte, grant_id, busy, timeout_err
  );

  modport master (
    output req_valid, req_byte, req_lock, transmit_ready, err_clr,
    input  req_ack, tx_ctrl, tx_byte, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select with an optional lock that reserves
// the grant for the last winner until its next byte shows up.
module rr_arbiter
  import hangman_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  input  logic            lock_hold_i,
  input  logic [ID_W-1:0] grant_id_i,
  output logic [ID_W-1:0] winner_o,
  output logic            any_grant_o
);

  logic [(1<<ID_W)-1:0] req_pad;
  logic [ID_W:0]        idx;

  assign req_pad = (1<<ID_W)'(req_i);

  always_comb begin
    winner_o    = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    if (lock_hold_i) begin
      if (req_pad[grant_id_i]) begin
        winner_o    = grant_id_i;
        any_grant_o = 1'b1;
      end
    end else begin
      // scan farthest offset first so the nearest valid index from rr_ptr wins
      for (int k = NREQ - 1; k >= 0; k--) begin
        idx = {1'b0, rr_ptr_i} + (ID_W+1)'(k);
        if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
        if (req_pad[idx[ID_W-1:0]]) begin
          winner_o    = idx[ID_W-1:0];
          any_grant_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_Tx between NREQ byte sources: grants, launches the frame,
// waits for completion and flags a transmitter that never starts.
module uart_tx_arbiter
  import hangman_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int                CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(NREQ - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              lock_hold_q, lock_hold_d;
  logic              err_q, err_d, err_set;
  logic [ID_W-1:0]   winner;
  logic              any_grant;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i       (bus.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .lock_hold_i (lock_hold_q),
    .grant_id_i  (grant_id_q),
    .winner_o    (winner),
    .any_grant_o (any_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ack_q   <= '0;
      tx_byte_q   <= '0;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      lock_hold_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ack_q   <= req_ack_d;
      tx_byte_q   <= tx_byte_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_hold_q <= lock_hold_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ack_d   = '0;
    tx_byte_d   = tx_byte_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    lock_hold_d = lock_hold_q;
    err_set     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.transmit_ready && any_grant) begin
          for (int i = 0; i < NREQ; i++) begin
            if (ID_W'(i) == winner) begin
              req_ack_d[i] = 1'b1;
              tx_byte_d    = bus.req_byte[i*BYTE_W +: BYTE_W];
              lock_hold_d  = bus.req_lock[i];
            end
          end
          grant_id_d = winner;
          rr_ptr_d   = (winner == LAST_ID) ? '0 : winner + 1'b1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (!bus.transmit_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_MAX) begin
          // transmitter never started: drop the byte and release any lock
          err_set     = 1'b1;
          lock_hold_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.transmit_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_set ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
  end

  assign bus.req_ack     = req_ack_q;
  assign bus.tx_ctrl     = (state_q == START);
  assign bus.tx_byte     = tx_byte_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.timeout_err = err_q;

endmodule
